// File: rtl/stb_dcache_arbiter.sv
// stb_dcache_arbiter: shares the single data-cache port between LSU load
// misses and store-buffer drain writes. Loads normally win; a saturating
// starvation counter and the stb_full override guarantee that stores drain.
// One transaction is outstanding at a time and every completion is followed
// by one IDLE cycle so a requester can drop its request before re-arbitration.
// Optional feature macro: STB_DCACHE_ARB_HAZARD_EN adds stb2arb_ld_hit, which
// makes a load that aliases a pending store ineligible until the store drains.
module stb_dcache_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lsu2arb_ld_req,
    input  logic [ADDR_W-1:0]   lsu2arb_ld_addr,
    output logic                arb2lsu_ld_ack,
    output logic [DATA_W-1:0]   arb2lsu_ld_data,
    input  logic                stb2arb_req,
    input  logic [ADDR_W-1:0]   stb2arb_addr,
    input  logic [DATA_W-1:0]   stb2arb_wdata,
    input  logic [DATA_W/8-1:0] stb2arb_sel,
    input  logic                stb_full,
`ifdef STB_DCACHE_ARB_HAZARD_EN
    input  logic                stb2arb_ld_hit,
`endif
    output logic                arb2stb_ack,
    output logic                arb2cache_req,
    output logic                arb2cache_w_en,
    output logic [ADDR_W-1:0]   arb2cache_addr,
    output logic [DATA_W-1:0]   arb2cache_wdata,
    output logic [DATA_W/8-1:0] arb2cache_sel,
    input  logic                cache2arb_ack,
    input  logic [DATA_W-1:0]   cache2arb_rdata
);

    localparam int         SEL_W      = DATA_W / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;

    logic ld_hit;
    logic ld_eligible;
    logic st_win;
    logic ld_win;
    logic busy;

`ifdef STB_DCACHE_ARB_HAZARD_EN
    assign ld_hit = stb2arb_ld_hit;
`else
    // Without hazard tracking, loads may bypass pending stores.
    assign ld_hit = 1'b0;
`endif

    // A full buffer with no drain request is an illegal combination: hold off loads too.
    assign ld_eligible = lsu2arb_ld_req && !ld_hit && !(stb_full && !stb2arb_req);
    assign st_win      = stb2arb_req && (stb_full || (starve_cnt_q == STARVE_LIM) || !ld_eligible);
    assign ld_win      = !st_win && ld_eligible;

    // Next-state, grant capture and starvation-counter update.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sel_d        = sel_q;
        case (state_q)
            IDLE: begin
                if (st_win) begin
                    state_d      = STORE;
                    addr_d       = stb2arb_addr;
                    wdata_d      = stb2arb_wdata;
                    sel_d        = stb2arb_sel;
                    starve_cnt_d = '0;
                end else if (ld_win) begin
                    state_d = LOAD;
                    addr_d  = lsu2arb_ld_addr;
                    wdata_d = '0;
                    sel_d   = '1;
                    if (!stb2arb_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_LIM) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (!stb2arb_req) begin
                    starve_cnt_d = '0;
                end
            end
            LOAD, STORE: begin
                // Completion always returns to IDLE for the one-cycle gap.
                if (cache2arb_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers; reset abandons any transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
        end
    end

    // Cache port is driven only from registers, so requester changes mid-transaction are invisible.
    assign busy            = (state_q != IDLE);
    assign arb2cache_req   = busy;
    assign arb2cache_w_en  = (state_q == STORE);
    assign arb2cache_addr  = busy ? addr_q  : '0;
    assign arb2cache_wdata = busy ? wdata_q : '0;
    assign arb2cache_sel   = busy ? sel_q   : '0;

    // Completion acks are same-cycle pulses; cache acks in IDLE are ignored.
    assign arb2lsu_ld_ack  = (state_q == LOAD)  && cache2arb_ack;
    assign arb2stb_ack     = (state_q == STORE) && cache2arb_ack;
    assign arb2lsu_ld_data = arb2lsu_ld_ack ? cache2arb_rdata : '0;

endmodule

// File: doc/stb_dcache_arbiter.md
Name: stb_dcache_arbiter

Overview:
- Shares the single data-cache port between two requesters: LSU load misses and store-buffer drain writes.
- Sits between the stb controller/datapath, the LSU dbus, and the dcache.
- Loads normally win, to keep load latency low.
- A bounded starvation counter, plus a full-buffer override, guarantees that stores drain.
- One transaction is outstanding at a time; each grant is held until the cache acknowledges it.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; sel width is DATA_W/8
- STARVE_MAX, 4, maximum number of consecutive load grants while a store is pending (range 1..15)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- lsu2arb_ld_req  in  1  load request; held until ack
- lsu2arb_ld_addr  in  ADDR_W  load address
- arb2lsu_ld_ack  out  1  load complete, 1-cycle pulse
- arb2lsu_ld_data  out  DATA_W  load data, valid with ack
- stb2arb_req  in  1  store-drain request (stb not empty); held until ack
- stb2arb_addr  in  ADDR_W  drain address
- stb2arb_wdata  in  DATA_W  drain data
- stb2arb_sel  in  DATA_W/8  byte select
- stb_full  in  1  store buffer full
- arb2stb_ack  out  1  drain write accepted, 1-cycle pulse (stb advances read pointer)
- arb2cache_req  out  1  cache request
- arb2cache_w_en  out  1  1 = write, 0 = read
- arb2cache_addr  out  ADDR_W  cache address
- arb2cache_wdata  out  DATA_W  cache write data
- arb2cache_sel  out  DATA_W/8  cache byte select
- cache2arb_ack  in  1  cache transaction done
- cache2arb_rdata  in  DATA_W  cache read data

Behaviour:
- Single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE, starve_cnt = 0.
  - Registered addr/wdata/sel = 0.
  - All outputs = 0.
  - A reset mid-transaction abandons the transaction; the cache is reset by the same rst_n.
- FSM states: IDLE, LOAD, STORE.
- IDLE arbitration (combinational, registered on the next clk edge):
  - Store wins if stb2arb_req and any of: stb_full, starve_cnt == STARVE_MAX, or !lsu2arb_ld_req.
  - Otherwise load wins if lsu2arb_ld_req.
  - Otherwise remain in IDLE.
- On grant:
  - Capture the winner's addr (plus wdata/sel for a store) into registers.
  - Enter LOAD or STORE.
- In LOAD / STORE:
  - arb2cache_req = 1 and the cache outputs are driven from the registers.
  - arb2cache_w_en = 1 only in STORE.
  - For a load, arb2cache_sel = all ones and arb2cache_wdata = 0.
- Latency: the request is sampled high in IDLE at edge N; arb2cache_req is high after edge N. Minimum load round trip is 1 cycle plus cache latency.
- Completion (cache2arb_ack high in LOAD/STORE):
  - Pulse the matching ack combinationally in that same cycle.
  - arb2lsu_ld_data = cache2arb_rdata in that cycle; it is 0 otherwise.
  - Next state is always IDLE.
  - The mandatory 1-cycle IDLE gap lets the requester drop its req, preventing a spurious regrant.
- Acks are never asserted outside LOAD/STORE; cache2arb_ack in IDLE is ignored.
- Starvation counter:
  - On a load grant while stb2arb_req = 1: starve_cnt increments, saturating at STARVE_MAX.
  - On a store grant, or any IDLE cycle with stb2arb_req = 0: starve_cnt resets to 0.
- Simultaneous requests with stb_full = 1: the store wins regardless of starve_cnt.
- stb_full = 1 with stb2arb_req = 0 is illegal; the arbiter grants nothing.
- Request inputs changing during LOAD/STORE have no effect, because registered values drive the cache.

Optional Feature:
- Macro: STB_DCACHE_ARB_HAZARD_EN.
- Defined:
  - Adds input port stb2arb_ld_hit (1 bit): the load address matches a pending stb entry.
  - In IDLE, a load with stb2arb_ld_hit = 1 is not eligible; stores drain first.
  - Eligibility is re-evaluated every IDLE cycle.
  - While the hit is blocking, starve_cnt does not increment.
- Undefined:
  - Port absent; the hit is treated as 0.
  - Loads may bypass pending stores; ordering is the LSU's responsibility.

Test Plan:
- Reset sequence: rst_n low mid-STORE with cache ack pending -> all outputs 0 immediately (asynchronous); state IDLE after release; starve_cnt = 0.
- Load only: ld_req = 1, addr 0x100, cache acks 2 cycles after req -> arb2cache_req high 1 cycle after ld_req with w_en = 0, addr 0x100; ld_ack pulses with data 0xDEADBEEF; one IDLE cycle follows.
- Store only: stb_req = 1, addr 0x200, wdata 0x12345678, sel 4'b0011 -> cache write with those values; arb2stb_ack pulses once; starve_cnt stays 0.
- Starvation (STARVE_MAX = 4): ld_req and stb_req continuously high, cache acks in 1 cycle -> grant order L, L, L, L, S, L, …
- Full override: both requests high, stb_full = 1, starve_cnt = 0 -> store granted first; the load follows after the IDLE gap.
- Hazard (macro on): ld_req with ld_hit = 1 and stb_req = 1 -> stores granted until ld_hit drops; then the load is granted; starve_cnt = 0 throughout.
